sqrt_scheduler: RTL and testbench

SQRT_SCHEDULER -- requirements
Module: sqrt_scheduler

---
 rtl/sqrt_pkg.sv | 16 +
 rtl/sqrt_resp_fifo.sv | 53 +++++
 rtl/sqrt_scheduler.sv | 126 ++++++++++++
 tb/tb_sqrt_scheduler.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sqrt_pkg.sv
// Shared widths, default core latency and the response record type for the
// square-root scheduler slice.
package sqrt_pkg;

    localparam int unsigned SQRT_IN_W  = 32;
    localparam int unsigned SQRT_OUT_W = 24;
    localparam int unsigned ID_W       = 3;
    localparam int unsigned DEF_LAT    = 20;

    // One queued response: core result plus the requester that owns it.
    typedef struct packed {
        logic [SQRT_OUT_W-1:0] data;
        logic [ID_W-1:0]       id;
    } resp_t;

endpackage

// File: rtl/sqrt_resp_fifo.sv
// Synchronous first-word-fall-through response queue.
// Ports:
//   clk, rst_b        clock, asynchronous active-low reset (clears pointers)
//   push, push_data   write request and record
//   pop               remove head (ignored when empty)
//   empty             no entries queued
//   head              record at the head of the queue (valid when !empty)
module sqrt_resp_fifo
    import sqrt_pkg::*;
#(
    parameter int unsigned DEPTH = 32
) (
    input  logic  clk,
    input  logic  rst_b,
    input  logic  push,
    input  resp_t push_data,
    input  logic  pop,
    output logic  empty,
    output resp_t head
);

    localparam int unsigned AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit; they run modulo 2*DEPTH.
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    resp_t       mem [DEPTH];
    logic        full;
    logic        do_push;
    logic        do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so push is legal even when full.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/sqrt_scheduler.sv
// Round-robin front end for a fixed-latency square-root core.
// Ports:
//   clk, rst_b                    clock, asynchronous active-low reset
//   req_valid/req_data/req_ready  NREQ requesters, 32-bit radicand each
//   core_in_valid/core_in_data    issue to the core (registered)
//   core_out_valid/core_out_data  core result, expected LAT cycles after issue
//   resp_valid/resp_ready         response handshake (FIFO head)
//   resp_data/resp_id             result and owning requester
//   err_sync                      sticky core/tag misalignment flag
module sqrt_scheduler
    import sqrt_pkg::*;
#(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned LAT   = DEF_LAT,
    parameter int unsigned DEPTH = 32
) (
    input  logic                       clk,
    input  logic                       rst_b,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [SQRT_IN_W*NREQ-1:0]  req_data,
    output logic [NREQ-1:0]            req_ready,
    output logic                       core_in_valid,
    output logic [SQRT_IN_W-1:0]       core_in_data,
    input  logic                       core_out_valid,
    input  logic [SQRT_OUT_W-1:0]      core_out_data,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [SQRT_OUT_W-1:0]      resp_data,
    output logic [ID_W-1:0]            resp_id,
    output logic                       err_sync
);

    localparam int unsigned         CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]       DEPTH_C = CW'(DEPTH);
    localparam logic [ID_W-1:0]     LAST_ID = ID_W'(NREQ - 1);

    logic [ID_W-1:0]  rr_ptr;      // first index searched this cycle
    logic [ID_W-1:0]  gnt_idx;
    logic             gnt_any;
    logic             grant;
    logic [CW-1:0]    used;        // in-flight + queued results
    logic [ID_W-1:0]  core_in_id;
    logic [LAT-1:0]   tag_v;
    logic [ID_W-1:0]  tag_id [LAT];
    logic             tag_out_v;
    logic             pop;
    logic             fifo_empty;
    resp_t            push_rec;
    resp_t            fifo_head;

    // Round-robin search beginning at rr_ptr.
    always_comb begin
        int unsigned idx;
        gnt_any = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (32'(rr_ptr) + k) % NREQ;
            if (!gnt_any && req_valid[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = ID_W'(idx);
            end
        end
    end

    // Gated by rst_b so req_ready drops in the same cycle reset is asserted.
    assign grant     = gnt_any && (used < DEPTH_C) && rst_b;
    assign req_ready = grant ? (NREQ'(1) << gnt_idx) : '0;

    assign tag_out_v = tag_v[LAT-1];
    assign pop       = resp_valid && resp_ready;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            rr_ptr        <= '0;
            core_in_valid <= 1'b0;
            core_in_data  <= '0;
            core_in_id    <= '0;
            used          <= '0;
            err_sync      <= 1'b0;
        end else begin
            core_in_valid <= grant;
            if (grant) begin
                core_in_data <= req_data[SQRT_IN_W*gnt_idx +: SQRT_IN_W];
                core_in_id   <= gnt_idx;
                rr_ptr       <= (gnt_idx == LAST_ID) ? '0 : gnt_idx + 1'b1;
            end
            unique case ({grant, pop})
                2'b10:   used <= used + 1'b1;
                2'b01:   used <= used - 1'b1;
                default: ;
            endcase
            if (core_out_valid != tag_out_v) err_sync <= 1'b1;
        end
    end

    // Tag line: mirrors the core pipeline, loaded when the core samples its input.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            tag_v <= '0;
            for (int unsigned i = 0; i < LAT; i++) tag_id[i] <= '0;
        end else begin
            tag_v     <= {tag_v[LAT-2:0], core_in_valid};
            tag_id[0] <= core_in_id;
            for (int unsigned i = 1; i < LAT; i++) tag_id[i] <= tag_id[i-1];
        end
    end

    assign push_rec.data = core_out_data;
    assign push_rec.id   = tag_id[LAT-1];

    sqrt_resp_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_b     (rst_b),
        .push      (tag_out_v),
        .push_data (push_rec),
        .pop       (pop),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    assign resp_valid = !fifo_empty;
    assign resp_data  = fifo_head.data;
    assign resp_id    = fifo_head.id;

endmodule

// File: tb/tb_sqrt_scheduler.sv
module tb_sqrt_scheduler;
    import sqrt_pkg::*;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned LAT   = 20;
    localparam int unsigned DEPTH = 32;

    logic                 clk = 1'b0;
    logic                 rst_b;
    logic [NREQ-1:0]      req_valid;
    logic [32*NREQ-1:0]   req_data;
    logic [NREQ-1:0]      req_ready;
    logic                 core_in_valid;
    logic [31:0]          core_in_data;
    logic                 core_out_valid;
    logic [23:0]          core_out_data;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [23:0]          resp_data;
    logic [2:0]           resp_id;
    logic                 err_sync;

    sqrt_scheduler #(.NREQ(NREQ), .LAT(LAT), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_b          (rst_b),
        .req_valid      (req_valid),
        .req_data       (req_data),
        .req_ready      (req_ready),
        .core_in_valid  (core_in_valid),
        .core_in_data   (core_in_data),
        .core_out_valid (core_out_valid),
        .core_out_data  (core_out_data),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_data      (resp_data),
        .resp_id        (resp_id),
        .err_sync       (err_sync)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural core: integer square root, LAT-cycle pipeline.
    function automatic logic [23:0] isqrt(input logic [31:0] v);
        logic [63:0] r;
        logic [63:0] t;
        r = '0;
        for (int i = 15; i >= 0; i--) begin
            t = r | (64'd1 << i);
            if (t * t <= {32'd0, v}) r = t;
        end
        return r[23:0];
    endfunction

    logic [LAT-1:0] cm_v;
    logic [23:0]    cm_d [LAT];
    logic           short_mode = 1'b0;   // deliver results one cycle early

    always @(posedge clk) begin
        cm_v    <= {cm_v[LAT-2:0], core_in_valid};
        cm_d[0] <= isqrt(core_in_data);
        for (int k = 1; k < LAT; k++) cm_d[k] <= cm_d[k-1];
    end

    assign core_out_valid = short_mode ? cm_v[LAT-2] : cm_v[LAT-1];
    assign core_out_data  = short_mode ? cm_d[LAT-2] : cm_d[LAT-1];

    // Scoreboard
    typedef struct {
        logic [2:0]  id;
        logic [23:0] data;
        bit          chk;
    } exp_t;

    exp_t        exp_q[$];
    int          grant_log[$];
    logic [23:0] exp_tab [NREQ];
    bit          chk_data = 1'b1;

    // Handshakes are sampled mid-cycle; each one pushes its expected response.
    always @(negedge clk) begin
        if (rst_b) begin
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    exp_t e;
                    e.id   = 3'(i);
                    e.data = exp_tab[i];
                    e.chk  = chk_data;
                    exp_q.push_back(e);
                    grant_log.push_back(i);
                end
            end
        end
    end

    // Monitor: every accepted response is popped and compared.
    always @(negedge clk) begin
        if (rst_b && resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_resp", {29'd0, resp_id}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("resp_id", {29'd0, resp_id}, {29'd0, e.id});
                if (e.chk) check("resp_data", {8'd0, resp_data}, {8'd0, e.data});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst_b     = 1'b0;
        req_valid = '0;
        exp_q.delete();
        grant_log.delete();
        repeat (3) @(posedge clk);
        #1 rst_b = 1'b1;
    endtask

    // Directed operands with hand-computed roots.
    logic [31:0] rad_tab [NREQ];

    initial begin
        int lat;
        int h;
        int cnt [NREQ];

        rad_tab[0] = 32'd0;         exp_tab[0] = 24'd0;
        rad_tab[1] = 32'd99;        exp_tab[1] = 24'd9;
        rad_tab[2] = 32'h0000_0100; exp_tab[2] = 24'h000010;
        rad_tab[3] = 32'hFFFF_FFFF; exp_tab[3] = 24'h00FFFF;
        for (int i = 0; i < NREQ; i++) req_data[32*i +: 32] = rad_tab[i];

        rst_b      = 1'b0;
        req_valid  = '0;
        resp_ready = 1'b1;
        repeat (25) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", {28'd0, req_ready}, 32'd0);
        check("rst_core_in_valid", {31'd0, core_in_valid}, 32'd0);
        check("rst_core_in_data", core_in_data, 32'd0);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_err_sync", {31'd0, err_sync}, 32'd0);
        @(posedge clk); #1 rst_b = 1'b1;

        // Single request from requester 2, latency 22 cycles.
        @(posedge clk); #1 req_valid = 4'b0100;
        @(negedge clk);
        check("single_ready", {28'd0, req_ready}, 32'b0100);
        h = cyc;
        @(posedge clk); #1 req_valid = '0;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (resp_valid) begin
                lat = cyc - h;
                break;
            end
        end
        check("single_latency", lat, 32'd22);
        repeat (5) @(posedge clk);
        check("single_drained", exp_q.size(), 32'd0);

        // Fairness: all requesters valid for 40 cycles.
        do_reset();
        @(posedge clk); #1 req_valid = 4'hF;
        repeat (40) @(posedge clk);
        #1 req_valid = '0;
        check("fair_grants", grant_log.size(), 32'd40);
        for (int i = 0; i < NREQ; i++) cnt[i] = 0;
        for (int i = 0; i < grant_log.size(); i++) begin
            check("fair_order", grant_log[i], i % NREQ);
            if (grant_log[i] < NREQ) cnt[grant_log[i]]++;
        end
        for (int i = 0; i < NREQ; i++) check("fair_count", cnt[i], 32'd10);
        repeat (40) @(posedge clk);
        check("fair_drained", exp_q.size(), 32'd0);

        // Backpressure: exactly DEPTH issues, then stream while full.
        do_reset();
        @(posedge clk); #1;
        resp_ready = 1'b0;
        req_valid  = 4'hF;
        repeat (60) @(posedge clk);
        @(negedge clk);
        check("bp_issues", grant_log.size(), DEPTH);
        check("bp_ready_low", {28'd0, req_ready}, 32'd0);
        check("bp_resp_valid", {31'd0, resp_valid}, 32'd1);
        @(posedge clk); #1 resp_ready = 1'b1;
        repeat (30) @(posedge clk);
        #1 req_valid = '0;
        repeat (60) @(posedge clk);
        @(negedge clk);
        check("bp_drained", exp_q.size(), 32'd0);
        check("bp_resp_idle", {31'd0, resp_valid}, 32'd0);

        // Misalignment: core returns one cycle early.
        do_reset();
        @(negedge clk);
        check("mis_err_before", {31'd0, err_sync}, 32'd0);
        @(posedge clk); #1;
        short_mode = 1'b1;
        chk_data   = 1'b0;
        req_valid  = 4'b0010;
        @(posedge clk); #1 req_valid = '0;
        repeat (30) @(posedge clk);
        #1;
        short_mode = 1'b0;
        chk_data   = 1'b1;
        check("mis_err_set", {31'd0, err_sync}, 32'd1);
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("mis_err_sticky", {31'd0, err_sync}, 32'd1);
        check("mis_drained", exp_q.size(), 32'd0);
        do_reset();
        @(negedge clk);
        check("mis_err_cleared", {31'd0, err_sync}, 32'd0);

        // Reset in the middle of a burst.
        @(posedge clk); #1 req_valid = 4'hF;
        repeat (30) @(posedge clk);
        @(negedge clk);
        check("mid_resp_valid_pre", {31'd0, resp_valid}, 32'd1);
        #1;
        rst_b     = 1'b0;
        req_valid = '0;
        exp_q.delete();
        #1;
        check("mid_req_ready", {28'd0, req_ready}, 32'd0);
        check("mid_core_in_valid", {31'd0, core_in_valid}, 32'd0);
        check("mid_core_in_data", core_in_data, 32'd0);
        check("mid_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("mid_err_sync", {31'd0, err_sync}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_b = 1'b1;
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("mid_err_after", {31'd0, err_sync}, 32'd1);
        check("mid_no_resp", {31'd0, resp_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
